// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter
//   Sole master of the VRAM byte-write port. Shares it between single-byte
//   CPU writes and a rectangle-fill engine that writes one 4-bit colour into
//   both nibbles of every byte of a clipped rectangle.
//
// Handshake rules (all ports):
//   A transfer happens on a cycle where valid && ready are both high. A source
//   holds valid and its payload stable until that cycle. o_vram_* are
//   registered; a new beat may be loaded in the completion cycle, so
//   o_vram_valid can stay high across back-to-back beats.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_cpu_*/o_cpu_ready      CPU byte-write request; ready pulses when the
//                            CPU's beat completes at the VRAM port
//   i_fill_*/o_fill_ready    fill command (x, y, w, h in bytes/rows, colour)
//   i_fill_abort             stop the running fill after any in-flight beat
//   o_fill_busy, o_fill_done engine not idle / one-cycle completion pulse
//   o_vram_*/i_vram_ready    byte-write beat to the video controller
module vram_write_arbiter #(
  parameter int WIDTH              = 128,
  parameter int HEIGHT             = 128,
  parameter int VRAM_ADDRESS_WIDTH = $clog2((WIDTH*HEIGHT+1)>>1)+1,
  parameter int ROW_BYTES          = WIDTH/2,
  localparam int AW = VRAM_ADDRESS_WIDTH-1,
  localparam int XW = $clog2(ROW_BYTES),
  localparam int YW = $clog2(HEIGHT),
  localparam int WW = $clog2(ROW_BYTES+1),
  localparam int HW = $clog2(HEIGHT+1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_valid,
  output logic          o_cpu_ready,
  input  logic [AW-1:0] i_cpu_adr,
  input  logic [7:0]    i_cpu_data,
  input  logic          i_fill_valid,
  output logic          o_fill_ready,
  input  logic [XW-1:0] i_fill_x,
  input  logic [YW-1:0] i_fill_y,
  input  logic [WW-1:0] i_fill_w,
  input  logic [HW-1:0] i_fill_h,
  input  logic [3:0]    i_fill_color,
  input  logic          i_fill_abort,
  output logic          o_fill_busy,
  output logic          o_fill_done,
  output logic          o_vram_valid,
  input  logic          i_vram_ready,
  output logic [AW-1:0] o_vram_adr,
  output logic [7:0]    o_vram_data
);

  // One bit wider than the widest operand so x+w / y+h cannot wrap.
  localparam int CXW = WW + 1;
  localparam int CYW = HW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_t;
  typedef enum logic {SRC_CPU, SRC_FILL} src_t;

  fill_state_t state, state_nxt;
  src_t        grant, last;

  logic [XW-1:0]  x0, col;
  logic [YW-1:0]  row;
  logic [CXW-1:0] x_end;
  logic [CYW-1:0] y_end;
  logic [3:0]     color;
  logic           abort_pend;

  logic [CXW-1:0] x_sum;
  logic [CYW-1:0] y_sum;
  logic           beat_done, cpu_beat_done, fill_beat_done, fill_in_out;
  logic           abort_hold, col_end, row_end;
  logic           out_free, cpu_elig, fill_elig, grant_cpu, grant_fill;
  logic [AW-1:0]  fill_adr;

  assign beat_done      = o_vram_valid && i_vram_ready;
  assign cpu_beat_done  = beat_done && (grant == SRC_CPU);
  assign fill_beat_done = beat_done && (grant == SRC_FILL);
  assign fill_in_out    = o_vram_valid && (grant == SRC_FILL);
  assign abort_hold     = abort_pend || i_fill_abort;

  assign o_cpu_ready  = cpu_beat_done;
  assign o_fill_ready = (state == S_IDLE) && !i_rst;
  assign o_fill_busy  = (state != S_IDLE);

  // Clipped end column/row, exclusive.
  assign x_sum = CXW'(i_fill_x) + CXW'(i_fill_w);
  assign y_sum = CYW'(i_fill_y) + CYW'(i_fill_h);

  assign col_end  = (CXW'(col) + CXW'(1)) == x_end;
  assign row_end  = (CYW'(row) + CYW'(1)) == y_end;
  assign fill_adr = AW'(row) * AW'(ROW_BYTES) + AW'(col);

  // A requester whose beat is completing right now is not eligible: its
  // request lines still show the old, already-serviced transfer.
  assign out_free   = !o_vram_valid || beat_done;
  assign cpu_elig   = i_cpu_valid && !cpu_beat_done;
  assign fill_elig  = (state == S_FILL) && !abort_hold && !fill_beat_done;
  assign grant_cpu  = out_free && cpu_elig && (!fill_elig || last == SRC_FILL);
  assign grant_fill = out_free && fill_elig && (!cpu_elig || last == SRC_CPU);

  // Output beat register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vram_valid <= 1'b0;
      o_vram_adr   <= '0;
      o_vram_data  <= '0;
      grant        <= SRC_CPU;
      last         <= SRC_FILL;
    end else if (grant_cpu) begin
      o_vram_valid <= 1'b1;
      o_vram_adr   <= i_cpu_adr;
      o_vram_data  <= i_cpu_data;
      grant        <= SRC_CPU;
      last         <= SRC_CPU;
    end else if (grant_fill) begin
      o_vram_valid <= 1'b1;
      o_vram_adr   <= fill_adr;
      o_vram_data  <= {color, color};
      grant        <= SRC_FILL;
      last         <= SRC_FILL;
    end else if (beat_done) begin
      o_vram_valid <= 1'b0;
    end
  end

  // Fill FSM: state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Fill FSM: next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (i_fill_valid)
          state_nxt = (i_fill_w == '0 || i_fill_h == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        if (fill_in_out) begin
          // An in-flight fill beat always finishes before stopping.
          if (fill_beat_done && ((col_end && row_end) || abort_hold))
            state_nxt = S_DONE;
        end else if (abort_hold) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fill command registers, walk counters and the done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x0          <= '0;
      col         <= '0;
      row         <= '0;
      x_end       <= '0;
      y_end       <= '0;
      color       <= '0;
      abort_pend  <= 1'b0;
      o_fill_done <= 1'b0;
    end else begin
      // Registered off DONE, so the pulse lands two cycles after the
      // deciding event.
      o_fill_done <= (state == S_DONE);
      if (state == S_IDLE && i_fill_valid) begin
        x0    <= i_fill_x;
        col   <= i_fill_x;
        row   <= i_fill_y;
        color <= i_fill_color;
        x_end <= (x_sum > CXW'(ROW_BYTES)) ? CXW'(ROW_BYTES) : x_sum;
        y_end <= (y_sum > CYW'(HEIGHT)) ? CYW'(HEIGHT) : y_sum;
      end
      if (state == S_FILL) begin
        if (i_fill_abort) abort_pend <= 1'b1;
        if (fill_beat_done) begin
          if (col_end) begin
            col <= x0;
            row <= row + YW'(1);
          end else begin
            col <= col + XW'(1);
          end
        end
      end else begin
        abort_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: clock/reset, driver tasks,
// a sink that raises ready one cycle after valid, a scoreboard of expected
// {address, data} beats, and a final report.
module tb_vram_write_arbiter;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_valid = 1'b0;
  logic          cpu_ready;
  logic [AW-1:0] cpu_adr = '0;
  logic [7:0]    cpu_data = '0;
  logic          fill_valid = 1'b0;
  logic          fill_ready;
  logic [5:0]    fill_x = '0;
  logic [6:0]    fill_y = '0;
  logic [6:0]    fill_w = '0;
  logic [7:0]    fill_h = '0;
  logic [3:0]    fill_color = '0;
  logic          fill_abort = 1'b0;
  logic          fill_busy;
  logic          fill_done;
  logic          vram_valid;
  logic          vram_ready = 1'b0;
  logic [AW-1:0] vram_adr;
  logic [7:0]    vram_data;

  vram_write_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_valid  (cpu_valid),
    .o_cpu_ready  (cpu_ready),
    .i_cpu_adr    (cpu_adr),
    .i_cpu_data   (cpu_data),
    .i_fill_valid (fill_valid),
    .o_fill_ready (fill_ready),
    .i_fill_x     (fill_x),
    .i_fill_y     (fill_y),
    .i_fill_w     (fill_w),
    .i_fill_h     (fill_h),
    .i_fill_color (fill_color),
    .i_fill_abort (fill_abort),
    .o_fill_busy  (fill_busy),
    .o_fill_done  (fill_done),
    .o_vram_valid (vram_valid),
    .i_vram_ready (vram_ready),
    .o_vram_adr   (vram_adr),
    .o_vram_data  (vram_data)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- sink: ready one cycle after valid ----------------
  initial begin
    logic v, r;
    forever begin
      @(negedge clk);
      v = vram_valid;
      r = vram_ready;
      @(posedge clk);
      #1 vram_ready = v && !r;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [AW+7:0] exp_q[$];
  int beat_cnt = 0;
  int cpu_beat_cnt = 0;
  int cpu_rdy_cnt = 0;
  int done_cnt = 0;
  int last_beat_cyc = 0;
  logic prev_cpu_ready = 1'b0;

  always @(negedge clk) begin
    logic [AW+7:0] e;
    if (!rst) begin
      if (vram_valid && vram_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {vram_adr, vram_data}, e);
        end
        beat_cnt++;
        last_beat_cyc = cyc;
        if (vram_adr == AW'(100) && vram_data == 8'h3c) cpu_beat_cnt++;
      end
      if (cpu_ready) begin
        check("cpu_ready_pulse", prev_cpu_ready, 0);
        cpu_rdy_cnt++;
      end
      if (fill_done) done_cnt++;
    end
    prev_cpu_ready = cpu_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic send_fill(input int x, input int y, input int w, input int h,
                           input int c, output int acc);
    acc = -1;
    @(posedge clk);
    #1;
    fill_valid = 1'b1;
    fill_x     = 6'(x);
    fill_y     = 7'(y);
    fill_w     = 7'(w);
    fill_h     = 8'(h);
    fill_color = 4'(c);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fill_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 fill_valid = 1'b0;
    check("fill_accept", acc >= 0, 1);
  endtask

  task automatic wait_done(output int dcyc, output bit busy_gap);
    dcyc = -1;
    busy_gap = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fill_done) begin
        dcyc = cyc;
        break;
      end
      if (!fill_busy) busy_gap = 1'b1;
    end
    check("done_seen", dcyc >= 0, 1);
  endtask

  task automatic cpu_writes(input int n);
    int got;
    got = 0;
    @(posedge clk);
    #1;
    cpu_valid = 1'b1;
    cpu_adr   = AW'(100);
    cpu_data  = 8'h3c;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clk);
      if (cpu_ready) got++;
    end
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    check("cpu_handshakes", got, n);
  endtask

  function automatic logic [AW+7:0] beat(input int adr, input int data);
    return {AW'(adr), 8'(data)};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int acc, dc, b0, d0, c0, r0;
    bit gap, found;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fill_ready", fill_ready, 0);
    check("rst_vram_valid", vram_valid, 0);
    check("rst_vram_adr", vram_adr, 0);
    check("rst_vram_data", vram_data, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_fill_ready", fill_ready, 1);

    // Basic fill
    b0 = beat_cnt; d0 = done_cnt;
    exp_q.push_back(beat(194, 8'h55));
    exp_q.push_back(beat(195, 8'h55));
    exp_q.push_back(beat(196, 8'h55));
    exp_q.push_back(beat(258, 8'h55));
    exp_q.push_back(beat(259, 8'h55));
    exp_q.push_back(beat(260, 8'h55));
    send_fill(2, 3, 3, 2, 5, acc);
    wait_done(dc, gap);
    repeat (3) @(negedge clk);
    check("basic_beats", beat_cnt - b0, 6);
    check("basic_q_empty", exp_q.size(), 0);
    check("basic_done_latency", dc - last_beat_cyc, 2);
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_busy_gap", gap, 0);

    // Clipping at the bottom-right corner
    b0 = beat_cnt; d0 = done_cnt;
    exp_q.push_back(beat(8190, 8'haa));
    exp_q.push_back(beat(8191, 8'haa));
    send_fill(62, 127, 5, 4, 10, acc);
    wait_done(dc, gap);
    repeat (3) @(negedge clk);
    check("clip_beats", beat_cnt - b0, 2);
    check("clip_q_empty", exp_q.size(), 0);
    check("clip_done_latency", dc - last_beat_cyc, 2);
    check("clip_done_once", done_cnt - d0, 1);

    // Empty command
    b0 = beat_cnt; d0 = done_cnt;
    send_fill(5, 5, 0, 7, 3, acc);
    wait_done(dc, gap);
    repeat (3) @(negedge clk);
    check("empty_beats", beat_cnt - b0, 0);
    check("empty_done_latency", dc - acc, 2);
    check("empty_done_once", done_cnt - d0, 1);

    // Contention with a continuously requesting CPU
    b0 = beat_cnt; d0 = done_cnt; c0 = cpu_beat_cnt; r0 = cpu_rdy_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(beat(100, 8'h3c));
      exp_q.push_back(beat(i, 8'h11));
    end
    fork
      send_fill(0, 0, 4, 1, 1, acc);
      cpu_writes(4);
    join
    wait_done(dc, gap);
    repeat (5) @(negedge clk);
    check("cont_beats", beat_cnt - b0, 8);
    check("cont_q_empty", exp_q.size(), 0);
    check("cont_cpu_beats", cpu_beat_cnt - c0, 4);
    check("cont_cpu_ready_cnt", cpu_rdy_cnt - r0, 4);
    check("cont_done_once", done_cnt - d0, 1);

    // Abort after the 5th fill beat is granted
    b0 = beat_cnt; d0 = done_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(beat(i, 8'h77));
    send_fill(0, 0, 64, 128, 7, acc);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vram_valid && vram_adr == AW'(4)) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_fifth_beat_seen", found, 1);
    @(posedge clk);
    #1 fill_abort = 1'b1;
    @(posedge clk);
    #1 fill_abort = 1'b0;
    wait_done(dc, gap);
    repeat (5) @(negedge clk);
    check("abort_beats", beat_cnt - b0, 5);
    check("abort_q_empty", exp_q.size(), 0);
    check("abort_done_once", done_cnt - d0, 1);

    // Next command after abort runs normally
    b0 = beat_cnt;
    exp_q.push_back(beat(650, 8'h33));
    send_fill(10, 10, 1, 1, 3, acc);
    wait_done(dc, gap);
    repeat (3) @(negedge clk);
    check("after_abort_beats", beat_cnt - b0, 1);
    check("after_abort_q_empty", exp_q.size(), 0);

    // Reset in the middle of a fill with a beat presented
    b0 = beat_cnt; d0 = done_cnt;
    send_fill(0, 0, 64, 128, 9, acc);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vram_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_valid_seen", found, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_fill_ready_in_rst", fill_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_vram_valid", vram_valid, 0);
    check("midrst_vram_adr", vram_adr, 0);
    check("midrst_vram_data", vram_data, 0);
    check("midrst_fill_busy", fill_busy, 0);
    check("midrst_fill_done", fill_done, 0);
    check("midrst_cpu_ready", cpu_ready, 0);
    check("midrst_fill_ready", fill_ready, 1);
    repeat (20) @(negedge clk);
    check("midrst_no_stale_beats", beat_cnt - b0, 0);
    check("midrst_no_done", done_cnt - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
